// File: rtl/header_checker_mc.sv
// rtl/header_checker_mc.sv - multi-channel event/spill package header checker
// Optional first-error capture outputs are enabled by defining HDRCHK_FIRST_ERR_EN.
module header_checker_mc #(
  parameter int N_CH        = 4,
  parameter int EVTNO_W     = 16,
  parameter int SPILLNO_W   = 10,
  parameter int CNT_W       = 8,
  parameter int EVTNO_START = 1,
  parameter int RESYNC      = 0,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      live_rising,
  input  logic [SPILLNO_W-1:0]      exp_spillno,
  input  logic [N_CH-1:0]           pkg_valid,
  input  logic [N_CH*EVTNO_W-1:0]   pkg_evtno,
  input  logic [N_CH*SPILLNO_W-1:0] pkg_spillno,
  input  logic                      err_clear,
  output logic [N_CH-1:0]           evtno_err,
  output logic [N_CH-1:0]           spillno_err,
  output logic [N_CH-1:0]           evtno_err_sticky,
  output logic [N_CH-1:0]           spillno_err_sticky,
  output logic [N_CH*CNT_W-1:0]     err_cnt,
`ifdef HDRCHK_FIRST_ERR_EN
  output logic                      first_err_valid,
  output logic [CH_W-1:0]           first_err_ch,
  output logic [EVTNO_W-1:0]        first_err_evtno,
`endif
  output logic [N_CH-1:0]           armed
);

  localparam logic [EVTNO_W-1:0] START = EVTNO_W'(EVTNO_START);
  localparam logic               IDLE  = 1'b0;
  localparam logic               ARMED = 1'b1;

  logic [N_CH-1:0] state_q;
  logic [N_CH-1:0] state_d;
  logic [N_CH-1:0] mis_vec;
  logic            clr_any;

  assign clr_any = live_rising | err_clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < N_CH; i++) begin
      case (state_q[i])
        IDLE:    if (live_rising) state_d[i] = ARMED;
        default: state_d[i] = ARMED;
      endcase
    end
  end

  always_comb begin
    armed = '0;
    for (int i = 0; i < N_CH; i++) armed[i] = (state_q[i] == ARMED);
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [EVTNO_W-1:0]   pkg_ev;
    logic [SPILLNO_W-1:0] pkg_sp;
    logic [EVTNO_W-1:0]   exp_q;
    logic [EVTNO_W-1:0]   exp_base;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_base;
    logic                 check;
    logic                 ev_mis;
    logic                 sp_mis;
    logic                 ev_err_q;
    logic                 sp_err_q;
    logic                 ev_st_q;
    logic                 sp_st_q;

    assign pkg_ev = pkg_evtno[i*EVTNO_W +: EVTNO_W];
    assign pkg_sp = pkg_spillno[i*SPILLNO_W +: SPILLNO_W];
    // A package arriving with live_rising is checked as the first of the new spill.
    assign check    = pkg_valid[i] & ((state_q[i] == ARMED) | live_rising);
    assign exp_base = live_rising ? START : exp_q;
    assign ev_mis   = check & (pkg_ev != exp_base);
    assign sp_mis   = check & (pkg_sp != exp_spillno);
    assign cnt_base = clr_any ? '0 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        exp_q    <= START;
        ev_err_q <= 1'b0;
        sp_err_q <= 1'b0;
        ev_st_q  <= 1'b0;
        sp_st_q  <= 1'b0;
        cnt_q    <= '0;
      end else begin
        if (check) begin
          ev_err_q <= ev_mis;
          sp_err_q <= sp_mis;
          exp_q    <= ((RESYNC != 0) && ev_mis) ? pkg_ev + 1'b1 : exp_base + 1'b1;
        end else if (live_rising) begin
          ev_err_q <= 1'b0;
          sp_err_q <= 1'b0;
          exp_q    <= START;
        end
        ev_st_q <= (ev_st_q & ~clr_any) | ev_mis;
        sp_st_q <= (sp_st_q & ~clr_any) | sp_mis;
        if ((ev_mis | sp_mis) && (cnt_base != {CNT_W{1'b1}})) cnt_q <= cnt_base + 1'b1;
        else                                                  cnt_q <= cnt_base;
      end
    end

    assign mis_vec[i]                    = ev_mis | sp_mis;
    assign evtno_err[i]                  = ev_err_q;
    assign spillno_err[i]                = sp_err_q;
    assign evtno_err_sticky[i]           = ev_st_q;
    assign spillno_err_sticky[i]         = sp_st_q;
    assign err_cnt[i*CNT_W +: CNT_W]     = cnt_q;
  end

`ifdef HDRCHK_FIRST_ERR_EN
  logic [CH_W-1:0]    sel_ch;
  logic [EVTNO_W-1:0] sel_ev;

  // Scan downwards so the lowest erroring channel is the one left selected.
  always_comb begin
    sel_ch = '0;
    sel_ev = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mis_vec[i]) begin
        sel_ch = CH_W'(i);
        sel_ev = pkg_evtno[i*EVTNO_W +: EVTNO_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_evtno <= '0;
    end else if ((|mis_vec) && (clr_any || !first_err_valid)) begin
      first_err_valid <= 1'b1;
      first_err_ch    <= sel_ch;
      first_err_evtno <= sel_ev;
    end else if (clr_any) begin
      first_err_valid <= 1'b0;
      first_err_ch    <= '0;
      first_err_evtno <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_header_checker_mc.sv
// tb/tb_header_checker_mc.sv - scoreboard bench for header_checker_mc (RESYNC=0 and RESYNC=1 instances)
module tb_header_checker_mc;
  localparam int N = 4, EW = 16, SW = 10, CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, live_rising, err_clear;
  logic [SW-1:0]   exp_spillno;
  logic [N-1:0]    pkg_valid;
  logic [N*EW-1:0] pkg_evtno;
  logic [N*SW-1:0] pkg_spillno;

  logic [N-1:0]    ee_a, se_a, es_a, ss_a, armed_a;
  logic [N-1:0]    ee_b, se_b, es_b, ss_b, armed_b;
  logic [N*CW-1:0] cnt_a, cnt_b;
`ifdef HDRCHK_FIRST_ERR_EN
  logic            fv_a, fv_b;
  logic [1:0]      fc_a, fc_b;
  logic [EW-1:0]   fe_a, fe_b;
`endif

  header_checker_mc #(.N_CH(N), .EVTNO_W(EW), .SPILLNO_W(SW), .CNT_W(CW), .EVTNO_START(1), .RESYNC(0)) dut_a (
    .clk(clk), .rst(rst), .live_rising(live_rising), .exp_spillno(exp_spillno),
    .pkg_valid(pkg_valid), .pkg_evtno(pkg_evtno), .pkg_spillno(pkg_spillno), .err_clear(err_clear),
    .evtno_err(ee_a), .spillno_err(se_a), .evtno_err_sticky(es_a), .spillno_err_sticky(ss_a),
    .err_cnt(cnt_a),
`ifdef HDRCHK_FIRST_ERR_EN
    .first_err_valid(fv_a), .first_err_ch(fc_a), .first_err_evtno(fe_a),
`endif
    .armed(armed_a));

  header_checker_mc #(.N_CH(N), .EVTNO_W(EW), .SPILLNO_W(SW), .CNT_W(CW), .EVTNO_START(1), .RESYNC(1)) dut_b (
    .clk(clk), .rst(rst), .live_rising(live_rising), .exp_spillno(exp_spillno),
    .pkg_valid(pkg_valid), .pkg_evtno(pkg_evtno), .pkg_spillno(pkg_spillno), .err_clear(err_clear),
    .evtno_err(ee_b), .spillno_err(se_b), .evtno_err_sticky(es_b), .spillno_err_sticky(ss_b),
    .err_cnt(cnt_b),
`ifdef HDRCHK_FIRST_ERR_EN
    .first_err_valid(fv_b), .first_err_ch(fc_b), .first_err_evtno(fe_b),
`endif
    .armed(armed_b));

  typedef struct packed {logic ee; logic se; logic es; logic ss; logic [CW-1:0] cnt;} res_t;
  typedef struct {int ch; res_t a; res_t b;} exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic res_t r(input logic ee, input logic se, input logic es, input logic ss, input logic [CW-1:0] cnt);
    return {ee, se, es, ss, cnt};
  endfunction

  task automatic exp2(input int ch, input res_t a, input res_t b);
    exp_t e;
    e.ch = ch; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic exp1(input int ch, input res_t x);
    exp2(ch, x, x);
  endtask

  function automatic res_t got_a(input int c);
    return {ee_a[c], se_a[c], es_a[c], ss_a[c], cnt_a[c*CW +: CW]};
  endfunction

  function automatic res_t got_b(input int c);
    return {ee_b[c], se_b[c], es_b[c], ss_b[c], cnt_b[c*CW +: CW]};
  endfunction

  // Monitor: one clock after each strobe, pop and compare per strobed channel.
  logic [N-1:0] strobe_d;
  always @(posedge clk) strobe_d <= pkg_valid;

  always @(negedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (strobe_d[c] === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty ch=%0d actual=no_entry required=entry", c);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk($sformatf("sb_ch_order_%0d", c), c, e.ch);
          chk($sformatf("ch%0d_resync0", c), got_a(c), e.a);
          chk($sformatf("ch%0d_resync1", c), got_b(c), e.b);
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] v, input logic [EW-1:0] e0, input logic [EW-1:0] e1,
                      input logic [EW-1:0] e2, input logic [EW-1:0] e3, input logic [SW-1:0] sp,
                      input logic lr, input logic clr);
    pkg_valid   = v;
    pkg_evtno   = {e3, e2, e1, e0};
    pkg_spillno = {sp, sp, sp, sp};
    live_rising = lr;
    err_clear   = clr;
    @(posedge clk);
    #1;
    pkg_valid   = '0;
    live_rising = 1'b0;
    err_clear   = 1'b0;
  endtask

  localparam res_t OK = '0;

  initial begin
    rst = 1'b1; live_rising = 1'b0; err_clear = 1'b0; exp_spillno = '0;
    pkg_valid = '0; pkg_evtno = '0; pkg_spillno = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("armed_rst", {armed_b, armed_a}, 0);
    chk("err_rst", {ee_b, se_b, ee_a, se_a}, 0);
    chk("sticky_rst", {es_b, ss_b, es_a, ss_a}, 0);
    chk("cnt_rst", {cnt_b, cnt_a}, 0);
`ifdef HDRCHK_FIRST_ERR_EN
    chk("first_valid_rst", {fv_b, fv_a}, 0);
`endif

    // Idle: strobes ignored
    for (int c = 0; c < N; c++) exp1(c, OK);
    send(4'hF, 16'h1234, 16'h0000, 16'hBEEF, 16'h0042, 10'd77, 1'b0, 1'b0);
    chk("armed_idle", {armed_b, armed_a}, 0);

    exp_spillno = 10'd5;
    send(4'h0, 0, 0, 0, 0, 10'd5, 1'b1, 1'b0);
    chk("armed_live", {armed_b, armed_a}, 8'hFF);

    // ch0 in-order packages, then a spill mismatch
    for (int e = 1; e <= 3; e++) begin
      exp1(0, OK);
      send(4'h1, EW'(e), 0, 0, 0, 10'd5, 1'b0, 1'b0);
    end
    exp1(0, r(0, 1, 0, 1, 1));
    send(4'h1, 16'd4, 0, 0, 0, 10'd6, 1'b0, 1'b0);

    // ch1 1,2,4,5
    exp1(1, OK);
    send(4'h2, 0, 16'd1, 0, 0, 10'd5, 1'b0, 1'b0);
    exp1(1, OK);
    send(4'h2, 0, 16'd2, 0, 0, 10'd5, 1'b0, 1'b0);
    exp1(1, r(1, 0, 1, 0, 1));
    send(4'h2, 0, 16'd4, 0, 0, 10'd5, 1'b0, 1'b0);
    exp2(1, r(1, 0, 1, 0, 2), r(0, 0, 1, 0, 1));
    send(4'h2, 0, 16'd5, 0, 0, 10'd5, 1'b0, 1'b0);

    // ch2 saturation, then clear coincident with an error
    for (int k = 1; k <= 5; k++) begin
      exp1(2, r(1, 0, 1, 0, (k > 3) ? 2'd3 : 2'(k)));
      send(4'h4, 0, 0, 16'd100, 0, 10'd5, 1'b0, 1'b0);
    end
    exp1(2, r(1, 0, 1, 0, 1));
    send(4'h4, 0, 0, 16'd100, 0, 10'd5, 1'b0, 1'b1);
    chk("clr_sticky_ch0_ch1", {ss_b[0], es_b[1], ss_a[0], es_a[1]}, 0);
    chk("clr_cnt_ch0_ch1", {cnt_b[3:0], cnt_a[3:0]}, 0);
    chk("clr_keeps_last", {ee_b[1], se_b[0], ee_a[1], se_a[0]}, 4'b0111);

    // ch3 wrap (reachable on the resync instance)
    exp1(3, r(1, 0, 1, 0, 1));
    send(4'h8, 0, 0, 0, 16'hFFFE, 10'd5, 1'b0, 1'b0);
    exp2(3, r(1, 0, 1, 0, 2), r(0, 0, 1, 0, 1));
    send(4'h8, 0, 0, 0, 16'hFFFF, 10'd5, 1'b0, 1'b0);
    exp2(3, r(1, 0, 1, 0, 3), r(0, 0, 1, 0, 1));
    send(4'h8, 0, 0, 0, 16'h0000, 10'd5, 1'b0, 1'b0);

    // live_rising coincident with a package, then continue
    exp1(3, OK);
    send(4'h8, 0, 0, 0, 16'd1, 10'd5, 1'b1, 1'b0);
    exp1(3, OK);
    send(4'h8, 0, 0, 0, 16'd2, 10'd5, 1'b0, 1'b0);
    chk("live_all_clear", {ee_b, se_b, es_b, ss_b, ee_a, se_a, es_a, ss_a}, 0);
    chk("live_cnt_clear", {cnt_b, cnt_a}, 0);
    exp_spillno = 10'd4;
    exp1(3, OK);
    send(4'h8, 0, 0, 0, 16'd3, 10'd4, 1'b0, 1'b0);
    exp_spillno = 10'd5;
`ifdef HDRCHK_FIRST_ERR_EN
    chk("first_valid_after_live", {fv_b, fv_a}, 0);
`endif

    // same-cycle errors on ch1 and ch3, later ch0, then clear+error
    exp1(1, r(1, 0, 1, 0, 1));
    exp1(3, r(1, 0, 1, 0, 1));
    send(4'hA, 0, 16'd7, 0, 16'd50, 10'd5, 1'b0, 1'b0);
`ifdef HDRCHK_FIRST_ERR_EN
    chk("first_tie_a", {fv_a, fc_a, fe_a}, {1'b1, 2'd1, 16'd7});
    chk("first_tie_b", {fv_b, fc_b, fe_b}, {1'b1, 2'd1, 16'd7});
`endif
    exp1(0, r(1, 0, 1, 0, 1));
    send(4'h1, 16'd40, 0, 0, 0, 10'd5, 1'b0, 1'b0);
`ifdef HDRCHK_FIRST_ERR_EN
    chk("first_frozen_a", {fv_a, fc_a, fe_a}, {1'b1, 2'd1, 16'd7});
    chk("first_frozen_b", {fv_b, fc_b, fe_b}, {1'b1, 2'd1, 16'd7});
`endif
    exp1(0, r(1, 0, 1, 0, 1));
    send(4'h1, 16'd90, 0, 0, 0, 10'd5, 1'b0, 1'b1);
`ifdef HDRCHK_FIRST_ERR_EN
    chk("first_clr_new_a", {fv_a, fc_a, fe_a}, {1'b1, 2'd0, 16'd90});
    chk("first_clr_new_b", {fv_b, fc_b, fe_b}, {1'b1, 2'd0, 16'd90});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
